ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Downstream consumer of the PS/2 scan-code FIFO receiver.
- Pops raw set-2 bytes through the receiver's ready/rdn read port and folds the 0xE0 (extended) and 0xF0 (break) prefixes into single key events.
- Tracks Shift and CapsLock state, translates make codes to ASCII, and presents one event at a time on a valid/ack port to the CPU/IO bus.

Parameters:
- ASCII_EN_DEF, 1, when 0 the ascii output is tied to 0 and the lookup table is not built.
- CAPS_CODE, 8'h58, scan code that toggles CapsLock on make.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- ps2_data  in  8  receiver FIFO head byte; valid while ps2_ready=1
- ps2_ready  in  1  receiver FIFO non-empty
- ps2_overflow  in  1  receiver FIFO overflow flag
- ps2_rdn  out  1  read strobe to receiver, active low, registered
- key_valid  out  1  event available; held until accepted
- key_ack  in  1  consumer accepts the event when key_valid=1
- key_code  out  8  final scan code, prefixes stripped
- key_ext  out  1  event was 0xE0-prefixed
- key_break  out  1  release event (0xF0-prefixed)
- key_lost  out  1  receiver overflow preceded this byte
- ascii  out  8  ASCII for make events, 0 otherwise
- shift  out  1  left or right Shift currently held
- caps  out  1  CapsLock latched state

Behaviour:
- Reset is asynchronous, rst_n=0. State=IDLE, ps2_rdn=1, key_valid=0. All event outputs, shift, caps, ext_flag, brk_flag and ovf_seen reset to 0. Reset mid-handshake drops any pending event; a byte already popped is lost.
- IDLE: when ps2_ready=1, go to FETCH.
- FETCH: lasts exactly one cycle with ps2_rdn=0.
  - Capture ps2_data into byte_r.
  - Capture ps2_overflow into ovf_seen.
  - Go to DECODE.
  - ps2_rdn is low only in FETCH, so exactly one pop occurs per byte.
- DECODE:
  - If ovf_seen=1, clear ext_flag and brk_flag first. This resynchronises the prefix state, and key_lost for this event is set to 1.
  - byte 0xE0: set ext_flag, go to IDLE, no event.
  - byte 0xF0: set brk_flag, go to IDLE, no event.
  - Any other byte: load key_code=byte, key_ext=ext_flag, key_break=brk_flag and key_lost=ovf_seen.
  - Compute ascii.
  - Update shift state:
    - Non-extended 0x12 (left) and 0x59 (right) set their bit on make and clear it on break.
    - shift = L|R.
  - Non-extended CAPS_CODE make toggles caps; its break has no effect.
  - Clear ext_flag and brk_flag, set key_valid=1, go to HOLD.
- HOLD: on key_valid&key_ack, clear key_valid and go to IDLE. key_ack while key_valid=0 is ignored.
- Latency: with ps2_ready=1 in IDLE at cycle N, FETCH is at N+1, DECODE at N+2, and key_valid=1 at N+3.
  - Minimum event spacing is 4 cycles after ack.
  - A prefixed key costs 3 cycles per prefix byte.
- No new byte is fetched while key_valid=1. Back-pressure accumulates in the receiver FIFO.
- ASCII rules:
  - Breaks, extended keys and unmapped codes give 0.
  - Letters give lowercase when shift^caps=0, uppercase otherwise.
  - Digit row gives 0-9, or the US shifted symbols when shift=1; caps does not affect digits.
  - 0x29 gives 0x20, 0x5A gives 0x0D, 0x66 gives 0x08, 0x0D gives 0x09, 0x76 gives 0x1B.
- Typematic repeats (make without an intervening break) each produce an event.
- Receiver-level bytes such as 0xAA and 0xFA are passed through as ordinary non-ext codes with ascii=0.

Optional Feature:
- Macro KEYDEC_BREAK_SUPPRESS_EN.
- When defined: break events still update shift and clear the flags in DECODE, but the block goes straight to IDLE without asserting key_valid. key_break is then constant 0.
- When undefined: break events are emitted as described above.

Decomposition:
- Package ps2_key_pkg holds:
  - state enum (IDLE, FETCH, DECODE, HOLD)
  - constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59, SC_CAPS default
  - the set-2 to ASCII table as constant functions
- One sub-module, ps2_ascii_lut: combinational, inputs code/shift/caps, output ascii.

Test Plan:
- FIFO bytes 0x1C then ack → one event: key_code=0x1C, ext=0, break=0, ascii=0x61, valid first seen 3 cycles after ready. Exactly one ps2_rdn low pulse per byte.
- Bytes 0x12, 0x1C, 0xF0 0x1C, 0xF0 0x12 → ascii=0x41 on the 0x1C make. The break event has key_break=1 and ascii=0. shift is 1 between the make and break of 0x12.
- Bytes 0x58, 0x1C, 0x12, 0x1C → caps=1, first 'A'=0x41, then with shift the second gives 'a'=0x61.
- Bytes 0xE0 0x75, 0xE0 0xF0 0x75 → key_code=0x75, key_ext=1, with break=0 then break=1 respectively, ascii=0.
- Hold key_ack=0 for 50 cycles with 3 bytes queued → ps2_rdn stays high, key_valid and key_code stay stable. After ack, the remaining bytes are popped in order.
- Byte 0xF0 then ps2_overflow=1 with byte 0x1C; separately, rst_n pulse while in HOLD → the 0x1C event has break=0 and key_lost=1. The reset clears valid, shift and caps immediately.

Source files
------------

// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg: shared FSM states, set-2 scan-code constants and the set-2 to ASCII lookup functions.
package ps2_key_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DECODE, HOLD} state_e;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  function automatic logic [7:0] sc_letter(input logic [7:0] c);
    case (c)
      8'h1C: return "a"; 8'h32: return "b"; 8'h21: return "c"; 8'h23: return "d";
      8'h24: return "e"; 8'h2B: return "f"; 8'h34: return "g"; 8'h33: return "h";
      8'h43: return "i"; 8'h3B: return "j"; 8'h42: return "k"; 8'h4B: return "l";
      8'h3A: return "m"; 8'h31: return "n"; 8'h44: return "o"; 8'h4D: return "p";
      8'h15: return "q"; 8'h2D: return "r"; 8'h1B: return "s"; 8'h2C: return "t";
      8'h3C: return "u"; 8'h2A: return "v"; 8'h1D: return "w"; 8'h22: return "x";
      8'h35: return "y"; 8'h1A: return "z";
      default: return 8'h00;
    endcase
  endfunction
  function automatic logic [7:0] sc_digit(input logic [7:0] c);
    case (c)
      8'h45: return "0"; 8'h16: return "1"; 8'h1E: return "2"; 8'h26: return "3";
      8'h25: return "4"; 8'h2E: return "5"; 8'h36: return "6"; 8'h3D: return "7";
      8'h3E: return "8"; 8'h46: return "9";
      default: return 8'h00;
    endcase
  endfunction
  // US-layout symbols on the shifted digit row
  function automatic logic [7:0] digit_shifted(input logic [7:0] d);
    case (d)
      "1": return "!"; "2": return "@"; "3": return "#"; "4": return "$"; "5": return "%";
      "6": return "^"; "7": return "&"; "8": return "*"; "9": return "("; "0": return ")";
      default: return 8'h00;
    endcase
  endfunction
  function automatic logic [7:0] sc_special(input logic [7:0] c);
    case (c)
      8'h29: return 8'h20; 8'h5A: return 8'h0D; 8'h66: return 8'h08;
      8'h0D: return 8'h09; 8'h76: return 8'h1B;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: key-event valid/ack port between the decoder (master) and the CPU/IO bus (slave).
interface ps2_key_decoder_if;
  logic       key_valid;
  logic       key_ack;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_lost;
  logic [7:0] ascii;
  modport master(output key_valid, key_code, key_ext, key_break, key_lost, ascii, input key_ack);
  modport slave(input key_valid, key_code, key_ext, key_break, key_lost, ascii, output key_ack);
endinterface

// File: rtl/ps2_ascii_lut.sv
// ps2_ascii_lut: combinational set-2 make code to ASCII; code_i/shift_i/caps_i in, ascii_o out (0 if unmapped).
module ps2_ascii_lut import ps2_key_pkg::*; (
  input  logic [7:0] code_i,
  input  logic       shift_i,
  input  logic       caps_i,
  output logic [7:0] ascii_o
);
  logic [7:0] let_c, dig_c;
  always_comb begin
    let_c = sc_letter(code_i);
    dig_c = sc_digit(code_i);
    ascii_o = let_c != 8'h00 ? ((shift_i ^ caps_i) ? let_c - 8'h20 : let_c)
            : dig_c != 8'h00 ? (shift_i ? digit_shifted(dig_c) : dig_c)
            : sc_special(code_i);
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: pops PS/2 set-2 bytes, folds E0/F0 prefixes into key events, tracks Shift/CapsLock, emits ASCII.
// Ports: clk, rst_n (async, active low); ps2_data/ps2_ready/ps2_overflow in and ps2_rdn out pop the receiver FIFO;
// key (ps2_key_decoder_if.master) carries the held-until-ack event; shift/caps expose modifier state.
// Build option KEYDEC_BREAK_SUPPRESS_EN: break events update modifiers but never raise key_valid.
module ps2_key_decoder import ps2_key_pkg::*; #(
  parameter bit         ASCII_EN_DEF = 1'b1,
  parameter logic [7:0] CAPS_CODE    = SC_CAPS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ps2_data,
  input  logic       ps2_ready,
  input  logic       ps2_overflow,
  output logic       ps2_rdn,
  output logic       shift,
  output logic       caps,
  ps2_key_decoder_if.master key
);
`ifdef KEYDEC_BREAK_SUPPRESS_EN
  localparam bit SUPPRESS = 1'b1;
`else
  localparam bit SUPPRESS = 1'b0;
`endif
  state_e     state_q;
  logic [7:0] byte_q, lut_c;
  logic       ovf_q, ext_q, brk_q, lsh_q, rsh_q, caps_q;
  logic       ext_c, brk_c, drop_c, plain_c;
  // a receiver overflow means prefix bytes may have been lost, so forget them
  assign ext_c   = ext_q & ~ovf_q;
  assign brk_c   = brk_q & ~ovf_q;
  assign drop_c  = SUPPRESS & brk_c;
  assign plain_c = ~ext_c;
  assign shift   = lsh_q | rsh_q;
  assign caps    = caps_q;
  if (ASCII_EN_DEF) begin : g_lut
    ps2_ascii_lut u_lut (.code_i(byte_q), .shift_i(shift), .caps_i(caps_q), .ascii_o(lut_c));
  end else begin : g_nolut
    assign lut_c = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= IDLE;
      ps2_rdn       <= 1'b1;
      byte_q        <= '0;
      ovf_q         <= 1'b0;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      lsh_q         <= 1'b0;
      rsh_q         <= 1'b0;
      caps_q        <= 1'b0;
      key.key_valid <= 1'b0;
      key.key_code  <= '0;
      key.key_ext   <= 1'b0;
      key.key_break <= 1'b0;
      key.key_lost  <= 1'b0;
      key.ascii     <= '0;
    end else begin
      case (state_q)
        IDLE: if (ps2_ready) begin
          state_q <= FETCH;
          ps2_rdn <= 1'b0;
        end
        FETCH: begin
          byte_q  <= ps2_data;
          ovf_q   <= ps2_overflow;
          ps2_rdn <= 1'b1;
          state_q <= DECODE;
        end
        DECODE: begin
          state_q <= IDLE;
          ext_q   <= 1'b0;
          brk_q   <= 1'b0;
          if (byte_q == SC_EXT) begin
            ext_q <= 1'b1;
            brk_q <= brk_c;
          end else if (byte_q == SC_BRK) begin
            ext_q <= ext_c;
            brk_q <= 1'b1;
          end else begin
            key.key_code  <= byte_q;
            key.key_ext   <= ext_c;
            key.key_break <= SUPPRESS ? 1'b0 : brk_c;
            key.key_lost  <= ovf_q;
            key.ascii     <= (ext_c | brk_c) ? 8'h00 : lut_c;
            if (plain_c && byte_q == SC_LSHIFT) lsh_q <= ~brk_c;
            if (plain_c && byte_q == SC_RSHIFT) rsh_q <= ~brk_c;
            if (plain_c && !brk_c && byte_q == CAPS_CODE) caps_q <= ~caps_q;
            key.key_valid <= ~drop_c;
            state_q       <= drop_c ? IDLE : HOLD;
          end
        end
        HOLD: if (key.key_ack) begin
          key.key_valid <= 1'b0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: FIFO model + event-level reference model for ps2_key_decoder, directed and random stimulus.
module tb_ps2_key_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ps2_data;
  logic       ps2_ready, ps2_overflow, ps2_rdn, shift, caps;
  ps2_key_decoder_if kif();
  ps2_key_decoder dut (
    .clk(clk), .rst_n(rst_n), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .ps2_overflow(ps2_overflow), .ps2_rdn(ps2_rdn), .shift(shift), .caps(caps), .key(kif)
  );
  always #10 clk = ~clk;
  typedef struct {logic [7:0] code; logic ext, brk, lost; logic [7:0] asc; logic sh, cp;} ev_t;
  ev_t        exp_q[$];
  ev_t        cur;
  logic [8:0] fifo[$];
  int         total = 0, bad = 0, cyc = 0, pushed = 0, pops = 0;
  logic       m_ext = 0, m_brk = 0, m_l = 0, m_r = 0, m_caps = 0;
  logic       auto_ack = 0, fifo_rd, rdn_prev = 0;
  string      lowers = "abcdefghijklmnopqrstuvwxyz";
  string      uppers = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
  string      digs   = "0123456789";
  string      syms   = ")!@#$%^&*(";
  logic [7:0] lcodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                              8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                              8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dcodes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input logic sh, input logic cp);
    for (int i = 0; i < 26; i++) if (lcodes[i] == c) return (sh ^ cp) ? uppers[i] : lowers[i];
    for (int i = 0; i < 10; i++) if (dcodes[i] == c) return sh ? syms[i] : digs[i];
    case (c)
      8'h29: return 8'h20; 8'h5A: return 8'h0D; 8'h66: return 8'h08;
      8'h0D: return 8'h09; 8'h76: return 8'h1B;
      default: return 8'h00;
    endcase
  endfunction
  // queue a byte in the receiver FIFO and run it through the event-level model
  task automatic push(input logic [7:0] b, input logic ovf = 1'b0);
    logic [7:0] a;
    fifo.push_back({ovf, b});
    pushed++;
    if (ovf) begin m_ext = 0; m_brk = 0; end
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      a = (m_ext || m_brk) ? 8'h00 : ref_ascii(b, m_l | m_r, m_caps);
      if (!m_ext && b == 8'h12) m_l = !m_brk;
      if (!m_ext && b == 8'h59) m_r = !m_brk;
      if (!m_ext && !m_brk && b == 8'h58) m_caps = !m_caps;
      exp_q.push_back('{b, m_ext, m_brk, ovf, a, m_l | m_r, m_caps});
      m_ext = 0;
      m_brk = 0;
    end
  endtask
  // receiver FIFO: pops the head on the edge that ends a cycle with ps2_rdn low
  initial begin
    ps2_ready = 0; ps2_data = 0; ps2_overflow = 0;
    forever begin
      @(negedge clk);
      fifo_rd = !ps2_rdn && rst_n;
      @(posedge clk);
      #1;
      if (fifo_rd && fifo.size() > 0) begin
        void'(fifo.pop_front());
        pops++;
      end
      ps2_ready = fifo.size() != 0;
      {ps2_overflow, ps2_data} = ps2_ready ? fifo[0] : 9'h0;
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (auto_ack) kif.key_ack = $urandom_range(0, 2) == 0;
  end
  always @(negedge clk) begin
    if (rst_n) begin
      if (!ps2_rdn) chk("rdn_width", rdn_prev, 0);
      rdn_prev = !ps2_rdn;
      if (kif.key_valid) begin
        chk("rdn_while_valid", ps2_rdn, 1);
        if (exp_q.size() == 0) chk("spurious_event", exp_q.size(), 1);
        else begin
          cur = exp_q[0];
          chk("key_code", kif.key_code, cur.code);
          chk("key_ext", kif.key_ext, cur.ext);
          chk("key_break", kif.key_break, cur.brk);
          chk("key_lost", kif.key_lost, cur.lost);
          chk("ascii", kif.ascii, cur.asc);
          chk("shift", shift, cur.sh);
          chk("caps", caps, cur.cp);
          if (kif.key_ack) void'(exp_q.pop_front());
        end
      end
    end else rdn_prev = 0;
  end
  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!kif.key_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!kif.key_valid) chk("valid_timeout", n, 0);
  endtask
  task automatic ack();
    @(posedge clk);
    #1 kif.key_ack = 1;
    @(posedge clk);
    #1 kif.key_ack = 0;
  endtask
  task automatic take(input logic [7:0] c, input logic e, input logic b, input logic l, input logic [7:0] a);
    wait_valid();
    chk("lit_code", kif.key_code, c);
    chk("lit_ext", kif.key_ext, e);
    chk("lit_break", kif.key_break, b);
    chk("lit_lost", kif.key_lost, l);
    chk("lit_ascii", kif.ascii, a);
    ack();
  endtask
  initial begin
    int n, t0;
    kif.key_ack = 0;
    repeat (3) @(negedge clk);
    chk("reset_valid", kif.key_valid, 0);
    chk("reset_rdn", ps2_rdn, 1);
    chk("reset_shift", shift, 0);
    chk("reset_caps", caps, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    // single make, with latency from ready to valid
    push(8'h1C);
    n = 0;
    @(negedge clk);
    while (!ps2_ready && n < 20) begin @(negedge clk); n++; end
    t0 = cyc;
    while (!kif.key_valid && n < 40) begin @(negedge clk); n++; end
    chk("latency", cyc - t0, 3);
    take(8'h1C, 0, 0, 0, 8'h61);
    // shifted letter, break of letter, break of shift
    push(8'h12); push(8'h1C); push(8'hF0); push(8'h1C); push(8'hF0); push(8'h12);
    take(8'h12, 0, 0, 0, 8'h00);
    take(8'h1C, 0, 0, 0, 8'h41);
    chk("shift_held", shift, 1);
    take(8'h1C, 0, 1, 0, 8'h00);
    take(8'h12, 0, 1, 0, 8'h00);
    chk("shift_released", shift, 0);
    // caps lock with and without shift
    push(8'h58); push(8'h1C); push(8'h12); push(8'h1C); push(8'hF0); push(8'h12);
    take(8'h58, 0, 0, 0, 8'h00);
    chk("caps_on", caps, 1);
    take(8'h1C, 0, 0, 0, 8'h41);
    take(8'h12, 0, 0, 0, 8'h00);
    take(8'h1C, 0, 0, 0, 8'h61);
    take(8'h12, 0, 1, 0, 8'h00);
    // extended make and break
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    take(8'h75, 1, 0, 0, 8'h00);
    take(8'h75, 1, 1, 0, 8'h00);
    // back-pressure: event held 50 cycles with two bytes still queued
    push(8'h1C); push(8'h32); push(8'h21);
    wait_valid();
    repeat (50) @(negedge clk);
    chk("hold_code", kif.key_code, 8'h1C);
    chk("hold_fifo", fifo.size(), 2);
    take(8'h1C, 0, 0, 0, 8'h41);
    take(8'h32, 0, 0, 0, 8'h42);
    take(8'h21, 0, 0, 0, 8'h43);
    // random byte stream with random overflow and random ack
    auto_ack = 1;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0: push(8'hE0, $urandom_range(0, 15) == 0);
        1: push(8'hF0, $urandom_range(0, 15) == 0);
        2: push(8'h12, $urandom_range(0, 15) == 0);
        3: push(8'h59, $urandom_range(0, 15) == 0);
        4: push(8'h58, $urandom_range(0, 15) == 0);
        5: push(8'($urandom), $urandom_range(0, 15) == 0);
        6: push(dcodes[$urandom_range(0, 9)], $urandom_range(0, 15) == 0);
        default: push(lcodes[$urandom_range(0, 25)], $urandom_range(0, 15) == 0);
      endcase
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    push(8'h29);
    n = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0) && n < 5000) begin @(negedge clk); n++; end
    chk("drain", fifo.size() + exp_q.size(), 0);
    auto_ack = 0;
    @(posedge clk);
    #2 kif.key_ack = 0;
    // overflow resync, then async reset while holding the event
    push(8'h12);
    wait_valid();
    ack();
    if (!m_caps) begin
      push(8'h58);
      wait_valid();
      ack();
    end
    push(8'hF0);
    push(8'h1C, 1'b1);
    wait_valid();
    chk("ovf_break", kif.key_break, 0);
    chk("ovf_lost", kif.key_lost, 1);
    chk("pre_reset_shift", shift, 1);
    chk("pre_reset_caps", caps, 1);
    @(posedge clk);
    #4 rst_n = 0;
    #1;
    chk("rst_valid", kif.key_valid, 0);
    chk("rst_shift", shift, 0);
    chk("rst_caps", caps, 0);
    chk("rst_rdn", ps2_rdn, 1);
    exp_q.delete();
    m_ext = 0; m_brk = 0; m_l = 0; m_r = 0; m_caps = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    push(8'h1C);
    take(8'h1C, 0, 0, 0, 8'h61);
    repeat (5) @(negedge clk);
    chk("pop_count", pops, pushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end
endmodule
